// File: rtl/des_sbox_hash_stream.sv
// des_sbox_hash_stream
//   Streaming byte hash with a 32-bit state (eight nibbles H[0..7]). Every
//   message byte is mixed through DES S-box S5 and then applied for N_ROUNDS
//   rounds. At end of message the wrapped byte count LEN is folded in, one
//   round per LEN byte (MSB first), and the digest is held until it is taken.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   msg_valid/ready   byte handshake (ready only while waiting for a byte)
//   msg_data          message byte
//   msg_last          final transfer of the message
//   msg_empty         with msg_last: msg_data is not part of the message
//   digest_valid      digest presented; held until digest_ready is sampled
//   digest_ready      consumer accepts the digest
//   digest            {H[0],...,H[7]}, shows the current state at all times

module des_sbox_hash_stream #(
  parameter int          N_ROUNDS = 4,
  parameter int          LEN_W    = 64,
  parameter logic [31:0] IV       = 32'h4B71_DF03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [7:0]  msg_data,
  input  logic        msg_last,
  input  logic        msg_empty,
  output logic        digest_valid,
  input  logic        digest_ready,
  output logic [31:0] digest
);

  localparam int         LEN_BYTES = LEN_W / 8;
  localparam logic [3:0] LAST_RND  = 4'(N_ROUNDS - 1);
  localparam logic [3:0] LAST_BYTE = 4'(LEN_BYTES - 1);

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_ABSORB = 2'd1,
    ST_FINAL  = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  // DES S5: row = {x[5],x[0]}, column = x[4:1]; each row is 16 nibbles,
  // column 0 in the most significant nibble.
  function automatic logic [3:0] sbox5(input logic [5:0] x);
    logic [63:0] row_v;
    case ({x[5], x[0]})
      2'b00:   row_v = 64'h2C41_7AB6_853F_D0E9;
      2'b01:   row_v = 64'hEB2C_47D1_50FA_3986;
      2'b10:   row_v = 64'h421B_AD78_F9C5_630E;
      2'b11:   row_v = 64'hB8C7_1E2D_6F09_A453;
      default: row_v = 64'h0000_0000_0000_0000;
    endcase
    return row_v[6'd63 - {x[4:1], 2'b00} -: 4];
  endfunction

  // Message byte to S-box input.
  function automatic logic [5:0] m6(input logic [7:0] d);
    return {d[3] ^ d[2], d[1], d[0], d[7], d[6], d[5] ^ d[4]};
  endfunction

  // Length byte to S-box input.
  function automatic logic [5:0] c6(input logic [7:0] c);
    return {c[7] ^ c[1], c[3], c[2], c[5] ^ c[0], c[4], c[6]};
  endfunction

  function automatic logic [3:0] rotl4(input logic [3:0] x, input logic [1:0] amt);
    logic [7:0] w;
    w = {x, x} << amt;
    return w[7:4];
  endfunction

  // One compression round: H'[i] = rotl(H[(i+1)%8] ^ s, i/2).
  function automatic logic [31:0] hash_round(input logic [31:0] h, input logic [3:0] s);
    logic [31:0] r;
    logic [3:0]  t;
    r = 32'h0000_0000;
    for (int i = 0; i < 8; i++) begin
      t = h[31 - 4 * ((i + 1) % 8) -: 4] ^ s;
      r[31 - 4 * i -: 4] = rotl4(t, 2'(i / 2));
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [31:0]       h_q, h_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [3:0]        s_q, s_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              msg_ready_q, msg_ready_d;
  logic              digest_valid_q, digest_valid_d;

  logic [3:0]        byte_idx;
  logic [7:0]        len_byte;
  logic [3:0]        round_s;
  logic [31:0]       round_h;

  // Select the LEN byte for the current finalisation round (MSB first).
  always_comb begin
    byte_idx = LAST_BYTE - cnt_q;
    len_byte = 8'h00;
    for (int k = 0; k < LEN_BYTES; k++) begin
      len_byte = (byte_idx == 4'(k)) ? len_q[8 * k +: 8] : len_byte;
    end
  end

  // Single shared round stage, fed by the latched byte S or the length S.
  always_comb begin
    if (state_q == ST_ABSORB) begin
      round_s = s_q;
    end else begin
      round_s = sbox5(c6(len_byte));
    end
    round_h = hash_round(h_q, round_s);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    len_d   = len_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      ST_ACCEPT: begin
        if (msg_valid) begin
          cnt_d = 4'd0;
          // msg_empty only counts on the last transfer.
          if (msg_last && msg_empty) begin
            state_d = ST_FINAL;
          end else begin
            s_d     = sbox5(m6(msg_data));
            len_d   = len_q + {{(LEN_W-1){1'b0}}, 1'b1};
            pend_d  = msg_last;
            state_d = ST_ABSORB;
          end
        end else begin
          state_d = ST_ACCEPT;
        end
      end
      ST_ABSORB: begin
        h_d = round_h;
        if (cnt_q == LAST_RND) begin
          cnt_d   = 4'd0;
          state_d = pend_q ? ST_FINAL : ST_ACCEPT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_FINAL: begin
        h_d = round_h;
        if (cnt_q == LAST_BYTE) begin
          cnt_d   = 4'd0;
          state_d = ST_OUT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_OUT: begin
        if (digest_ready) begin
          h_d     = IV;
          len_d   = {LEN_W{1'b0}};
          pend_d  = 1'b0;
          state_d = ST_ACCEPT;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_ACCEPT;
      end
    endcase
    msg_ready_d    = (state_d == ST_ACCEPT);
    digest_valid_d = (state_d == ST_OUT);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_ACCEPT;
      h_q            <= IV;
      len_q          <= {LEN_W{1'b0}};
      s_q            <= 4'd0;
      cnt_q          <= 4'd0;
      pend_q         <= 1'b0;
      msg_ready_q    <= 1'b1;
      digest_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      h_q            <= h_d;
      len_q          <= len_d;
      s_q            <= s_d;
      cnt_q          <= cnt_d;
      pend_q         <= pend_d;
      msg_ready_q    <= msg_ready_d;
      digest_valid_q <= digest_valid_d;
    end
  end

  assign msg_ready    = msg_ready_q;
  assign digest_valid = digest_valid_q;
  assign digest       = h_q;

endmodule
